// File: rtl/mac_acc_v2.sv
// mac_acc_v2: accumulation stage behind the MAC datapath.
// It delays in_vld by the MAC latency to mark which MAC results are real.
// It sums len valid terms into one result and saturates that result to 16 bits.
// Results leave through a small first-word fall-through FIFO.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; arriving terms are ignored
// RUN   | taking terms, pushing one result per len terms
// DONE  | one-cycle end-of-run marker (done=1); returns to IDLE
module mac_acc_v2 #(
  parameter int MAC_LAT    = 7,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [LEN_W-1:0] n_out,
  input  logic             in_vld,
  input  logic [15:0]      res,
  output logic [15:0]      out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             drop
);

  localparam int ACC_W = 16 + LEN_W;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]              DEPTH_C = (AW + 1)'(FIFO_DEPTH);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [MAC_LAT-1:0]        vld_sr_q, vld_sr_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [LEN_W-1:0]          nout_q, nout_d;
  logic [LEN_W-1:0]          term_cnt_q, term_cnt_d;
  logic [LEN_W-1:0]          out_cnt_q, out_cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      ovf_q, ovf_d;
  logic                      drop_q, drop_d;
  logic [15:0]               mem_q [FIFO_DEPTH];
  logic [15:0]               mem_d [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [AW:0]               cnt_q, cnt_d;

  logic                      vld_tail;
  logic signed [ACC_W-1:0]   sum;
  logic                      sat_hi, sat_lo;
  logic [15:0]               sat_val;
  logic                      push, pop, full, wr_en;

  assign vld_tail = vld_sr_q[MAC_LAT-1];
  assign sum      = acc_q + {{LEN_W{res[15]}}, res};
  assign sat_hi   = (sum > SAT_MAX);
  assign sat_lo   = (sum < SAT_MIN);
  assign sat_val  = sat_hi ? 16'h7FFF : (sat_lo ? 16'h8000 : sum[15:0]);

  assign out_vld  = (cnt_q != '0);
  assign out_data = out_vld ? mem_q[rd_ptr_q] : 16'h0000;
  assign pop      = out_vld & out_rdy;
  assign full     = (cnt_q == DEPTH_C);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign ovf      = ovf_q;
  assign drop     = drop_q;

  // Valid delay line: free-running shift of in_vld, tail aligns with res.
  always_comb begin
    vld_sr_d[0] = in_vld;
    for (int i = 1; i < MAC_LAT; i++) vld_sr_d[i] = vld_sr_q[i-1];
  end

  // Sequencer and accumulator: next state, term/result counting, sticky flags.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    nout_d     = nout_q;
    term_cnt_d = term_cnt_q;
    out_cnt_d  = out_cnt_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          len_d      = (len == '0) ? LEN_W'(1) : len;
          nout_d     = (n_out == '0) ? LEN_W'(1) : n_out;
          term_cnt_d = '0;
          out_cnt_d  = '0;
          acc_d      = '0;
          ovf_d      = 1'b0;
          drop_d     = 1'b0;
        end
      end
      S_RUN: begin
        if (vld_tail) begin
          if (term_cnt_q + LEN_W'(1) == len_q) begin
            // Group complete: clear in the same edge so the next group can follow directly.
            push       = 1'b1;
            acc_d      = '0;
            term_cnt_d = '0;
            out_cnt_d  = out_cnt_q + LEN_W'(1);
            if (sat_hi || sat_lo) ovf_d = 1'b1;
            if (full && !pop) drop_d = 1'b1;
            if (out_cnt_d == nout_q) state_d = S_DONE;
          end else begin
            acc_d      = sum;
            term_cnt_d = term_cnt_q + LEN_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output FIFO: a push is kept when there is room or a pop frees a slot in the same cycle.
  always_comb begin
    wr_en = push & (~full | pop);
    mem_d = mem_q;
    if (wr_en) mem_d[wr_ptr_q] = sat_val;
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW + 1)'(wr_en) - (AW + 1)'(pop);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      vld_sr_q   <= '0;
      len_q      <= '0;
      nout_q     <= '0;
      term_cnt_q <= '0;
      out_cnt_q  <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= 1'b0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      vld_sr_q   <= vld_sr_d;
      len_q      <= len_d;
      nout_q     <= nout_d;
      term_cnt_q <= term_cnt_d;
      out_cnt_q  <= out_cnt_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mac_acc_v2.sv
// Directed bench for mac_acc_v2. A small delay-line model stands in for the MAC.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mac_acc_v2;

  localparam int MAC_LAT = 7;
  localparam int LEN_W   = 16;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [LEN_W-1:0] n_out = '0;
  logic             in_vld = 1'b0;
  logic [15:0]      res_in = 16'h0;
  logic [15:0]      res;
  logic [15:0]      out_data;
  logic             out_vld;
  logic             out_rdy = 1'b0;
  logic             busy, done, ovf, drop;
  logic [15:0]      mac_pipe [MAC_LAT];

  int n_chk  = 0;
  int n_pass = 0;
  int w;

  always #5 clk = ~clk;

  // MAC stand-in: the value driven with in_vld appears at res MAC_LAT cycles later.
  always @(posedge clk) begin
    mac_pipe[0] <= res_in;
    for (int i = 1; i < MAC_LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
  end
  assign res = mac_pipe[MAC_LAT-1];

  mac_acc_v2 #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .len(len), .n_out(n_out),
    .in_vld(in_vld), .res(res), .out_data(out_data), .out_vld(out_vld),
    .out_rdy(out_rdy), .busy(busy), .done(done), .ovf(ovf), .drop(drop)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic term(input logic [15:0] v);
    in_vld = 1'b1; res_in = v;
    cyc();
    in_vld = 1'b0; res_in = 16'h0;
  endtask

  task automatic kick_term(input logic [LEN_W-1:0] l, input logic [LEN_W-1:0] n, input logic [15:0] v);
    start = 1'b1; len = l; n_out = n;
    in_vld = 1'b1; res_in = v;
    cyc();
    start = 1'b0; in_vld = 1'b0; res_in = 16'h0;
  endtask

  task automatic wait_vld(input int budget, output int waited);
    waited = 0;
    while (!out_vld && waited < budget) begin cyc(); waited++; end
    check("wait_out_vld", {31'd0, out_vld}, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin cyc(); k++; end
    check("wait_done", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin cyc(); k++; end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset values.
    repeat (3) cyc();
    check("rst_out_vld",  {31'd0, out_vld}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_busy",     {31'd0, busy}, 32'd0);
    check("rst_done",     {31'd0, done}, 32'd0);
    check("rst_ovf",      {31'd0, ovf}, 32'd0);
    check("rst_drop",     {31'd0, drop}, 32'd0);
    rstn = 1'b1;
    cyc();

    // len=4: 4 x 0x0200 -> 0x0800; term in the start cycle counts.
    out_rdy = 1'b1;
    kick_term(4, 1, 16'h0200);
    check("t1_busy_after_start", {31'd0, busy}, 32'd1);
    repeat (3) term(16'h0200);
    wait_vld(30, w);
    check("t1_latency", w, 32'd7);
    check("t1_data", {16'd0, out_data}, 32'h0800);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_ovf",  {31'd0, ovf}, 32'd0);
    check("t1_drop", {31'd0, drop}, 32'd0);
    cyc();
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    check("t1_done_end", {31'd0, done}, 32'd0);
    check("t1_vld_end",  {31'd0, out_vld}, 32'd0);

    // Positive saturation: 3 x 0x7000 = 86016 -> 0x7FFF.
    kick_term(3, 1, 16'h7000);
    repeat (2) term(16'h7000);
    wait_vld(30, w);
    check("t2_pos_data", {16'd0, out_data}, 32'h7FFF);
    check("t2_pos_ovf",  {31'd0, ovf}, 32'd1);
    wait_idle(10);

    // Negative saturation: 3 x 0x9000 = -86016 -> 0x8000; ovf cleared by start.
    start = 1'b1; len = 3; n_out = 1;
    cyc();
    start = 1'b0;
    check("t2_ovf_cleared", {31'd0, ovf}, 32'd0);
    repeat (3) term(16'h9000);
    check("t2_ovf_before_push", {31'd0, ovf}, 32'd0);
    wait_vld(30, w);
    check("t2_neg_data", {16'd0, out_data}, 32'h8000);
    check("t2_neg_ovf",  {31'd0, ovf}, 32'd1);
    wait_idle(10);

    // len=1, n_out=4, back-to-back, out_rdy=1.
    kick_term(1, 4, 16'h0001);
    term(16'h0002); term(16'h0003); term(16'h0004);
    wait_vld(30, w);
    for (int i = 0; i < 4; i++) begin
      check("t3_vld",  {31'd0, out_vld}, 32'd1);
      check("t3_data", {16'd0, out_data}, i + 1);
      check("t3_done", {31'd0, done}, (i == 3) ? 32'd1 : 32'd0);
      cyc();
    end
    check("t3_vld_end", {31'd0, out_vld}, 32'd0);
    wait_idle(10);

    // Backpressure: 6 results into a 4-deep FIFO with out_rdy=0.
    out_rdy = 1'b0;
    kick_term(1, 6, 16'h0001);
    for (int i = 2; i <= 6; i++) term(16'(i));
    wait_done(30);
    check("t4_drop", {31'd0, drop}, 32'd1);
    check("t4_ovf",  {31'd0, ovf}, 32'd0);
    check("t4_vld",  {31'd0, out_vld}, 32'd1);
    wait_idle(10);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t4_drain_vld",  {31'd0, out_vld}, 32'd1);
      check("t4_drain_data", {16'd0, out_data}, i + 1);
      cyc();
    end
    check("t4_vld_end", {31'd0, out_vld}, 32'd0);

    // Gating: a term reaching the accumulator 3 cycles before start is ignored.
    term(16'h0400);
    repeat (9) cyc();
    kick_term(2, 1, 16'h0100);
    repeat (5) cyc();
    term(16'h0100);
    wait_vld(30, w);
    check("t5_data", {16'd0, out_data}, 32'h0200);
    wait_idle(10);

    // Reset mid-run with a FIFO entry pending and a term in flight.
    out_rdy = 1'b0;
    kick_term(1, 1, 16'h0055);
    wait_idle(20);
    check("t6_pending", {31'd0, out_vld}, 32'd1);
    kick_term(8, 2, 16'h0010);
    repeat (3) term(16'h0010);
    repeat (8) cyc();
    check("t6_busy_pre", {31'd0, busy}, 32'd1);
    term(16'h1000);
    rstn = 1'b0;
    cyc();
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_vld",  {31'd0, out_vld}, 32'd0);
    check("t6_rst_ovf",  {31'd0, ovf}, 32'd0);
    check("t6_rst_data", {16'd0, out_data}, 32'd0);
    rstn = 1'b1;
    out_rdy = 1'b1;
    kick_term(2, 1, 16'h0010);
    term(16'h0020);
    wait_vld(30, w);
    check("t6_data", {16'd0, out_data}, 32'h0030);
    check("t6_done", {31'd0, done}, 32'd1);
    wait_idle(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
